// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - two-byte SPI frame sequencer with one-entry input buffer
//
// Takes a 14-bit value over a valid/ready handshake and sends it to an external
// byte-wide SPI master as two bytes under one slave-select window: MSB first,
// {2'b00, value[13:8]}, then LSB, value[7:0]. A fixed idle gap separates the
// bytes and follows the frame. A per-byte watchdog aborts a frame whose byte
// never completes and raises a sticky error flag.
//
// Parameters:
//   GAP_CYCLES      idle cycles between the bytes and after the frame (1..255)
//   TIMEOUT_CYCLES  maximum cycles to wait for spi_done per byte (2..65535)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   data_in      value to transmit
//   data_valid   data_in offered
//   data_ready   pending slot empty; transfer on data_valid && data_ready
//   spi_ready    SPI master idle, able to start a byte
//   spi_done     one-cycle pulse, byte shifted out
//   spi_start    one-cycle pulse, start a byte
//   spi_tx_data  byte to the SPI master
//   ss_n         slave select, active low
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse, frame completed
//   timeout_err  sticky error flag, cleared when the next frame is loaded

module spi_frame_sequencer #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        spi_ready,
    input  logic        spi_done,
    output logic        spi_start,
    output logic [7:0]  spi_tx_data,
    output logic        ss_n,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SS_SETUP = 3'd1,
        LOAD_MSB = 3'd2,
        WAIT_MSB = 3'd3,
        GAP      = 3'd4,
        LOAD_LSB = 3'd5,
        WAIT_LSB = 3'd6,
        SS_HOLD  = 3'd7
    } state_t;

    // Terminal counts: counters start at 0 on state entry, so the state is
    // occupied for exactly (last + 1) cycles.
    localparam logic [7:0]  GAP_LAST     = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [13:0] pend_data;
    logic        pend_v;
    logic [13:0] frame_reg;
    logic [7:0]  gap_cnt;
    logic [15:0] timeout_cnt;
    logic        accept;

    assign data_ready = !pend_v;
    assign accept     = data_valid && !pend_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pend_data   <= 14'd0;
            pend_v      <= 1'b0;
            frame_reg   <= 14'd0;
            gap_cnt     <= 8'd0;
            timeout_cnt <= 16'd0;
            spi_start   <= 1'b0;
            spi_tx_data <= 8'h00;
            ss_n        <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Pulses default low; counters default to zero so that any state
            // change clears them and only a counting state that stays put
            // advances its counter.
            spi_start   <= 1'b0;
            frame_done  <= 1'b0;
            gap_cnt     <= 8'd0;
            timeout_cnt <= 16'd0;

            // Load never collides with the IDLE consume below: accept needs
            // pend_v low, the consume needs it high.
            if (accept) begin
                pend_data <= data_in;
                pend_v    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend_v) begin
                        frame_reg   <= pend_data;
                        pend_v      <= 1'b0;
                        timeout_err <= 1'b0;
                        ss_n        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SS_SETUP;
                    end
                end

                SS_SETUP: begin
                    state <= LOAD_MSB;
                end

                LOAD_MSB: begin
                    if (spi_ready) begin
                        spi_start   <= 1'b1;
                        spi_tx_data <= {2'b00, frame_reg[13:8]};
                        state       <= WAIT_MSB;
                    end
                end

                WAIT_MSB: begin
                    // spi_done wins over an expiring watchdog in the same cycle.
                    if (spi_done) begin
                        state <= GAP;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        ss_n        <= 1'b1;
                        state       <= SS_HOLD;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= LOAD_LSB;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                LOAD_LSB: begin
                    if (spi_ready) begin
                        spi_start   <= 1'b1;
                        spi_tx_data <= frame_reg[7:0];
                        state       <= WAIT_LSB;
                    end
                end

                WAIT_LSB: begin
                    if (spi_done) begin
                        frame_done <= 1'b1;
                        ss_n       <= 1'b1;
                        state      <= SS_HOLD;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        ss_n        <= 1'b1;
                        state       <= SS_HOLD;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                SS_HOLD: begin
                    // Returning through IDLE guarantees at least one IDLE
                    // cycle even when a value is already queued.
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    ss_n  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - directed self-checking bench for spi_frame_sequencer

module tb_spi_frame_sequencer;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [13:0] data_in    = 14'd0;
    logic        data_valid = 1'b0;
    logic        spi_ready  = 1'b1;
    logic        spi_done   = 1'b0;
    logic        data_ready;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        ss_n;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    // Activity log, sampled on the falling edge.
    int         cyc      = 0;
    int         fd_cnt   = 0;
    int         fd_cyc   = 0;
    int         hold_cnt = 0;
    logic [8:0] start_log[$];
    int         start_cyc[$];

    // Behavioural SPI master: spi_done arrives done_delay cycles after spi_start.
    int done_delay = 8;
    bit resp_en    = 1'b1;

    spi_frame_sequencer #(
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .spi_ready   (spi_ready),
        .spi_done    (spi_done),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .ss_n        (ss_n),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (spi_start) begin
            start_log.push_back({ss_n, spi_tx_data});
            start_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (busy && ss_n) hold_cnt++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (spi_start && resp_en) begin
                repeat (done_delay) @(negedge clk);
                spi_done = 1'b1;
                @(negedge clk);
                spi_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] log_at(input int i);
        if (i < start_log.size()) return start_log[i];
        return 9'h1FF;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < start_cyc.size()) return start_cyc[i];
        return -1000;
    endfunction

    task automatic clear_logs();
        start_log.delete();
        start_cyc.delete();
        fd_cnt   = 0;
        fd_cyc   = 0;
        hold_cnt = 0;
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [13:0] v);
        bit ok;
        ok         = 1'b0;
        data_in    = v;
        data_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (data_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    initial begin
        bit ok;
        int seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data_ready", data_ready, 1'b1);
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_tx_data", spi_tx_data, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();

        // Basic frame
        send(14'h1ABC);
        wait_idle("basic_idle");
        check("basic_nbytes", start_log.size(), 2);
        check("basic_msb", log_at(0), {1'b0, 8'h1A});
        check("basic_lsb", log_at(1), {1'b0, 8'hBC});
        check("basic_gap_spacing", cyc_at(1) - cyc_at(0), 14);
        check("basic_frame_done_cnt", fd_cnt, 1);
        check("basic_frame_done_time", fd_cyc - cyc_at(1), 9);
        check("basic_ss_hold_len", hold_cnt, 4);

        // Back-pressure: second value queues, third stalls
        clear_logs();
        send(14'h3FFF);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_busy", ok, 1'b1);
        send(14'h0001);
        data_in    = 14'h1234;
        data_valid = 1'b1;
        @(negedge clk);
        check("bp_stall_ready", data_ready, 1'b0);
        repeat (5) @(negedge clk);
        check("bp_stall_hold", data_ready, 1'b0);
        send(14'h1234);
        wait_idle("bp_idle");
        check("bp_nbytes", start_log.size(), 6);
        check("bp_b0", log_at(0), {1'b0, 8'h3F});
        check("bp_b1", log_at(1), {1'b0, 8'hFF});
        check("bp_b2", log_at(2), {1'b0, 8'h00});
        check("bp_b3", log_at(3), {1'b0, 8'h01});
        check("bp_b4", log_at(4), {1'b0, 8'h12});
        check("bp_b5", log_at(5), {1'b0, 8'h34});
        check("bp_frame_done_cnt", fd_cnt, 3);

        // spi_ready held low in LOAD_MSB
        clear_logs();
        spi_ready = 1'b0;
        send(14'h0555);
        repeat (2) @(negedge clk);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (spi_start) seen++;
            @(negedge clk);
        end
        check("rdy_no_start", seen, 0);
        check("rdy_ss_low", ss_n, 1'b0);
        spi_ready = 1'b1;
        @(negedge clk);
        check("rdy_start", spi_start, 1'b1);
        check("rdy_tx_msb", spi_tx_data, 8'h05);
        wait_idle("rdy_idle");
        check("rdy_lsb", log_at(1), {1'b0, 8'h55});

        // Timeout on the MSB byte
        clear_logs();
        resp_en = 1'b0;
        send(14'h2AAA);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_start", ok, 1'b1);
        repeat (15) @(negedge clk);
        check("to_err_before", timeout_err, 1'b0);
        check("to_ss_before", ss_n, 1'b0);
        @(negedge clk);
        check("to_err_set", timeout_err, 1'b1);
        check("to_ss_high", ss_n, 1'b1);
        wait_idle("to_idle");
        check("to_no_frame_done", fd_cnt, 0);
        check("to_sticky", timeout_err, 1'b1);
        check("to_one_start", start_log.size(), 1);
        clear_logs();
        resp_en = 1'b1;
        send(14'h0100);
        check("to_sticky_pending", timeout_err, 1'b1);
        @(negedge clk);
        check("to_cleared_on_load", timeout_err, 1'b0);
        wait_idle("to_next_idle");
        check("to_next_msb", log_at(0), {1'b0, 8'h01});
        check("to_next_lsb", log_at(1), {1'b0, 8'h00});
        check("to_next_frame_done", fd_cnt, 1);

        // Zero value, spi_done on the last watchdog cycle
        clear_logs();
        done_delay = 15;
        send(14'h0000);
        wait_idle("edge_idle");
        check("edge_nbytes", start_log.size(), 2);
        check("edge_msb", log_at(0), {1'b0, 8'h00});
        check("edge_lsb", log_at(1), {1'b0, 8'h00});
        check("edge_frame_done", fd_cnt, 1);
        check("edge_no_timeout", timeout_err, 1'b0);
        done_delay = 8;

        // Reset in WAIT_LSB, then a stray spi_done from the master
        clear_logs();
        send(14'h1ABC);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (spi_start && spi_tx_data == 8'hBC) begin
                ok = 1'b1;
                break;
            end
        end
        check("rm_lsb_start", ok, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rm_data_ready", data_ready, 1'b1);
        check("rm_spi_start", spi_start, 1'b0);
        check("rm_tx_data", spi_tx_data, 8'h00);
        check("rm_ss_n", ss_n, 1'b1);
        check("rm_busy", busy, 1'b0);
        check("rm_frame_done", frame_done, 1'b0);
        check("rm_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (20) @(negedge clk);
        check("rm_no_restart", start_log.size(), 0);
        check("rm_no_frame_done", fd_cnt, 0);
        check("rm_still_idle", busy, 1'b0);
        check("rm_ss_high", ss_n, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
